fastram_arbiter: RTL and testbench

FASTRAM_ARBITER -- requirements
Module: fastram_arbiter

---
 rtl/fastram_arb_pkg.sv | 24 ++
 rtl/fastram_arb_pick.sv | 29 ++
 rtl/fastram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fastram_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fastram_arb_pkg.sv
// Shared types for the FastRAM arbiter: FSM states, port indices and grant encodings.
// Used by fastram_arbiter and fastram_arb_pick; FASTRAM_ARB_RR_EN selects round-robin ties.
package fastram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        ACK       = 3'd4
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_A    = 2'b01;
    localparam logic [1:0] GRANT_B    = 2'b10;

    function automatic logic grant_port(input logic [1:0] g);
        return (g == GRANT_B) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/fastram_arb_pick.sv
// Combinational winner selection between the CPU (a) and disk DMA (b) ports.
// FASTRAM_ARB_RR_EN: ties go to the port not served last; otherwise port a always wins ties.
module fastram_arb_pick
    import fastram_arb_pkg::*;
(
    input  logic       a_req_i,
    input  logic       b_req_i,
`ifdef FASTRAM_ARB_RR_EN
    input  logic       last_port_i,
`endif
    output logic [1:0] pick_o
);

    always_comb begin
        pick_o = GRANT_NONE;
        if (a_req_i && b_req_i) begin
`ifdef FASTRAM_ARB_RR_EN
            pick_o = (last_port_i == PORT_A) ? GRANT_B : GRANT_A;
`else
            pick_o = GRANT_A;
`endif
        end else if (a_req_i) begin
            pick_o = GRANT_A;
        end else if (b_req_i) begin
            pick_o = GRANT_B;
        end
    end

endmodule

// File: rtl/fastram_arbiter.sv
// Two-port arbiter onto a single SDRAM channel with busy handshake and rise timeout.
// FASTRAM_ARB_RR_EN enables round-robin tie-breaking (a last-served register); default is fixed a-priority.
//
// state     | meaning
// IDLE      | wait for a request while the channel is free, latch winner
// ISSUE     | one-cycle mem_rd/mem_wr strobe from the latched access
// WAIT_RISE | wait for mem_busy to rise, bounded by BUSY_TO
// WAIT_FALL | wait for mem_busy to fall, capture read data
// ACK       | pulse the winner's ack, release grant
module fastram_arbiter
    import fastram_arb_pkg::*;
#(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 8,
    parameter int BUSY_TO = 15
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_busy,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(BUSY_TO + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TO);

    arb_state_e        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] a_dout_q, a_dout_d;
    logic [DATA_W-1:0] b_dout_q, b_dout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        pick;

`ifdef FASTRAM_ARB_RR_EN
    logic last_q, last_d;

    fastram_arb_pick u_pick (
        .a_req_i     (a_req),
        .b_req_i     (b_req),
        .last_port_i (last_q),
        .pick_o      (pick)
    );
`else
    fastram_arb_pick u_pick (
        .a_req_i (a_req),
        .b_req_i (b_req),
        .pick_o  (pick)
    );
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        a_dout_d = a_dout_q;
        b_dout_d = b_dout_q;
        cnt_d    = '0;
`ifdef FASTRAM_ARB_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick != GRANT_NONE && !mem_busy) begin
                    grant_d = pick;
                    we_d    = (pick == GRANT_B) ? b_we   : a_we;
                    addr_d  = (pick == GRANT_B) ? b_addr : a_addr;
                    din_d   = (pick == GRANT_B) ? b_din  : a_din;
                    state_d = ISSUE;
                end
            end
            // Holding here while busy keeps the strobe off an occupied channel.
            ISSUE: begin
                if (!mem_busy) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (mem_busy) begin
                    state_d = WAIT_FALL;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ACK;
                end
            end
            WAIT_FALL: begin
                if (!mem_busy) begin
                    if (!we_q) begin
                        if (grant_port(grant_q) == PORT_B) b_dout_d = mem_dout;
                        else                               a_dout_d = mem_dout;
                    end
                    state_d = ACK;
                end
            end
            ACK: begin
                grant_d = GRANT_NONE;
                state_d = IDLE;
`ifdef FASTRAM_ARB_RR_EN
                last_d  = grant_port(grant_q);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= GRANT_NONE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            a_dout_q <= '0;
            b_dout_q <= '0;
            cnt_q    <= '0;
`ifdef FASTRAM_ARB_RR_EN
            last_q   <= PORT_B;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            a_dout_q <= a_dout_d;
            b_dout_q <= b_dout_d;
            cnt_q    <= cnt_d;
`ifdef FASTRAM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign mem_rd   = (state_q == ISSUE) && !mem_busy && !we_q;
    assign mem_wr   = (state_q == ISSUE) && !mem_busy &&  we_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign a_ack    = (state_q == ACK) && (grant_q == GRANT_A);
    assign b_ack    = (state_q == ACK) && (grant_q == GRANT_B);
    assign a_dout   = a_dout_q;
    assign b_dout   = b_dout_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_fastram_arbiter.sv
// Self-checking bench for fastram_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fastram_arbiter;

    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 8;
    localparam int BUSY_TO = 15;
`ifdef FASTRAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              a_req = 1'b0, a_we = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_din = '0;
    logic [DATA_W-1:0] a_dout;
    logic              a_ack;
    logic              b_req = 1'b0, b_we = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_din = '0;
    logic [DATA_W-1:0] b_dout;
    logic              b_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout = '0;
    logic              mem_wr, mem_rd, mem_busy;
    logic [1:0]        grant;
    logic              resp_busy = 1'b0, ext_busy = 1'b0;

    assign mem_busy = resp_busy | ext_busy;

    always #5 clk_sys = ~clk_sys;

    fastram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUSY_TO(BUSY_TO)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_ack(b_ack),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .mem_busy(mem_busy), .grant(grant)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Memory responder: busy for resp_len cycles starting the cycle after a strobe.
    int                resp_len  = 0;
    logic [DATA_W-1:0] resp_data = '0;
    initial begin
        int len;
        forever begin
            @(negedge clk_sys);
            if ((mem_rd || mem_wr) && resp_len > 0) begin
                len = resp_len;
                @(posedge clk_sys);
                #1;
                resp_busy = 1'b1;
                mem_dout  = 8'hEE;
                repeat (len) @(posedge clk_sys);
                #1;
                resp_busy = 1'b0;
                mem_dout  = resp_data;
            end
        end
    end

    // Transaction model: one access in flight, tracked by the cycle indices of its events.
    int                cyc = 0;
    bit                model_live = 1'b0;
    bit                m_rst = 1'b0;
    int                m_own = 0;          // 0 none, 1 port a, 2 port b
    logic              m_we = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_din = '0;
    int                m_strobe = -1, m_rise = -1, m_ack = -1;
    logic [DATA_W-1:0] m_adout = '0, m_bdout = '0;
    int                m_last = 2;

    always @(posedge clk_sys) begin
        model_live = 1'b1;
        m_rst = !reset_n;
        if (!reset_n) begin
            m_own = 0; m_strobe = -1; m_rise = -1; m_ack = -1;
            m_adout = '0; m_bdout = '0; m_last = 2;
        end else if (m_own == 0) begin
            if ((a_req || b_req) && !mem_busy) begin
                if (a_req && b_req) m_own = (RR_EN && m_last == 1) ? 2 : 1;
                else                m_own = a_req ? 1 : 2;
                m_we   = (m_own == 1) ? a_we   : b_we;
                m_addr = (m_own == 1) ? a_addr : b_addr;
                m_din  = (m_own == 1) ? a_din  : b_din;
            end
        end else if (m_strobe < 0) begin
            if (!mem_busy) m_strobe = cyc;
        end else if (m_ack == cyc) begin
            m_last = m_own; m_own = 0; m_strobe = -1; m_rise = -1; m_ack = -1;
        end else if (m_ack < 0) begin
            if (m_rise < 0) begin
                if (mem_busy)                          m_rise = cyc;
                else if (cyc - m_strobe == BUSY_TO + 1) m_ack = cyc + 1;
            end else if (!mem_busy) begin
                if (!m_we) begin
                    if (m_own == 1) m_adout = mem_dout;
                    else            m_bdout = mem_dout;
                end
                m_ack = cyc + 1;
            end
        end
        cyc++;
    end

    // Event log used by the directed literal checks.
    int                rd_cnt = 0, wr_cnt = 0, strobe_cnt = 0, a_ack_cnt = 0, b_ack_cnt = 0;
    int                last_strobe_cyc = 0, last_ack_cyc = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [DATA_W-1:0] last_din = '0;
    logic [1:0]        strobe_grant = '0;
    int                ack_q[$];
    bit                exp_strobe;
    logic [1:0]        exp_grant;

    always @(negedge clk_sys) begin
        if (model_live) begin
            if (m_rst) begin
                check("rst_grant", grant, 0);
                check("rst_mem_rd", mem_rd, 0);
                check("rst_mem_wr", mem_wr, 0);
                check("rst_a_ack", a_ack, 0);
                check("rst_b_ack", b_ack, 0);
                check("rst_a_dout", a_dout, 0);
                check("rst_b_dout", b_dout, 0);
                check("rst_mem_addr", mem_addr, 0);
                check("rst_mem_din", mem_din, 0);
            end else begin
                exp_strobe = (m_own != 0) && (m_strobe < 0) && !mem_busy;
                exp_grant  = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
                check("grant", grant, exp_grant);
                check("mem_rd", mem_rd, exp_strobe && !m_we);
                check("mem_wr", mem_wr, exp_strobe && m_we);
                if (exp_strobe) begin
                    check("mem_addr", mem_addr, m_addr);
                    if (m_we) check("mem_din", mem_din, m_din);
                end
                check("a_ack", a_ack, (m_own == 1) && (m_ack == cyc));
                check("b_ack", b_ack, (m_own == 2) && (m_ack == cyc));
                check("a_dout", a_dout, m_adout);
                check("b_dout", b_dout, m_bdout);
                check("strobe_vs_busy", (mem_rd || mem_wr) && mem_busy, 0);
                check("strobe_excl", mem_rd && mem_wr, 0);
            end
            if (mem_rd || mem_wr) begin
                strobe_cnt++;
                if (mem_rd) rd_cnt++; else wr_cnt++;
                last_strobe_cyc = cyc;
                last_addr = mem_addr;
                last_din = mem_din;
                strobe_grant = grant;
            end
            if (a_ack) begin a_ack_cnt++; ack_q.push_back(1); last_ack_cyc = cyc; end
            if (b_ack) begin b_ack_cnt++; ack_q.push_back(2); last_ack_cyc = cyc; end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_ack(input int port, input int budget, input string name);
        int n;
        n = 0;
        while (!((port == 1) ? a_ack : b_ack)) begin
            if (n >= budget) begin
                bound_fail(name);
                return;
            end
            tick();
            n++;
        end
    endtask

    initial begin
        int c0, rd0, wr0, ack0, s0, n, r;
        int exp_order[4];

        repeat (3) tick();
        check("reset_grant_lit", grant, 2'b00);
        reset_n = 1'b1;
        tick();

        // Single read on port a.
        resp_len = 3; resp_data = 8'h5A;
        a_we = 1'b0; a_addr = 23'h000123; a_req = 1'b1;
        c0 = cyc;
        wait_ack(1, 40, "read_ack_wait");
        a_req = 1'b0;
        repeat (2) tick();
        check("read_rd_count", rd_cnt, 1);
        check("read_wr_count", wr_cnt, 0);
        check("read_addr", last_addr, 23'h000123);
        check("read_grant", strobe_grant, 2'b01);
        check("read_strobe_lat", last_strobe_cyc - c0, 1);
        check("read_ack_lat", last_ack_cyc - last_strobe_cyc, 5);
        check("read_ack_count", a_ack_cnt, 1);
        check("read_dout", a_dout, 8'h5A);

        // Single write on port b.
        rd0 = rd_cnt; wr0 = wr_cnt; ack0 = b_ack_cnt;
        resp_len = 2; resp_data = 8'h00;
        b_we = 1'b1; b_addr = 23'h7FFFFF; b_din = 8'hC3; b_req = 1'b1;
        wait_ack(2, 40, "write_ack_wait");
        b_req = 1'b0;
        repeat (2) tick();
        check("write_wr_count", wr_cnt - wr0, 1);
        check("write_rd_count", rd_cnt - rd0, 0);
        check("write_addr", last_addr, 23'h7FFFFF);
        check("write_din", last_din, 8'hC3);
        check("write_grant", strobe_grant, 2'b10);
        check("write_ack_count", b_ack_cnt - ack0, 1);

        // Contention: both ports held high for four accesses.
        ack_q.delete();
        resp_len = 1; resp_data = 8'h91;
        a_we = 1'b0; a_addr = 23'h000010;
        b_we = 1'b1; b_addr = 23'h000020; b_din = 8'h77;
        a_req = 1'b1; b_req = 1'b1;
        n = 0;
        while (ack_q.size() < 4 && n < 200) begin tick(); n++; end
        a_req = 1'b0; b_req = 1'b0;
        if (ack_q.size() < 4) bound_fail("contention_wait");
        repeat (3) tick();
        if (RR_EN) exp_order = '{1, 2, 1, 2};
        else       exp_order = '{1, 1, 1, 1};
        check("contention_count", ack_q.size(), 4);
        for (int i = 0; i < 4 && i < ack_q.size(); i++) check($sformatf("contention_order%0d", i), ack_q[i], exp_order[i]);

        // Timeout: busy never rises.
        resp_len = 0;
        a_we = 1'b0; a_addr = 23'h000055; a_req = 1'b1;
        wait_ack(1, 60, "timeout_ack_wait");
        a_req = 1'b0;
        repeat (2) tick();
        check("timeout_lat", last_ack_cyc - last_strobe_cyc, BUSY_TO + 2);
        check("timeout_dout_kept", a_dout, 8'h91);
        check("timeout_idle_grant", grant, 2'b00);

        // Reset during WAIT_FALL abandons the access.
        resp_len = 6; resp_data = 8'hAB;
        a_we = 1'b0; a_addr = 23'h000066; a_req = 1'b1;
        s0 = strobe_cnt; n = 0;
        while (strobe_cnt == s0 && n < 20) begin tick(); n++; end
        if (strobe_cnt == s0) bound_fail("reset_strobe_wait");
        ack0 = a_ack_cnt;
        tick();
        reset_n = 1'b0;
        a_req = 1'b0;
        tick();
        check("reset_mid_grant", grant, 2'b00);
        check("reset_mid_dout", a_dout, 8'h00);
        check("reset_mid_rd", mem_rd, 1'b0);
        repeat (2) tick();
        reset_n = 1'b1;
        n = 0;
        while (mem_busy && n < 20) begin tick(); n++; end
        check("reset_no_ack", a_ack_cnt - ack0, 0);
        resp_len = 2; resp_data = 8'h3C;
        a_addr = 23'h000067; a_req = 1'b1;
        wait_ack(1, 40, "post_reset_ack_wait");
        a_req = 1'b0;
        repeat (2) tick();
        check("post_reset_ack_count", a_ack_cnt - ack0, 1);
        check("post_reset_dout", a_dout, 8'h3C);

        // External busy gates issue; strobe follows release by one cycle.
        resp_len = 1; resp_data = 8'h42;
        ext_busy = 1'b1;
        a_we = 1'b0; a_addr = 23'h000077; a_req = 1'b1;
        s0 = strobe_cnt;
        repeat (5) tick();
        check("gate_no_strobe", strobe_cnt - s0, 0);
        check("gate_no_grant", grant, 2'b00);
        ext_busy = 1'b0;
        r = cyc;
        wait_ack(1, 40, "gate_ack_wait");
        a_req = 1'b0;
        repeat (2) tick();
        check("gate_strobe_lat", last_strobe_cyc - r, 1);
        check("gate_dout", a_dout, 8'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
